// File: rtl/sisc_ctrl_mc.sv
// SISC multi-cycle controller: sequences fetch/decode/execute/mem/writeback
// and drives PC, IR, register-file, ALU and memory-port control strobes.
module sisc_ctrl_mc #(
   parameter int OP_W         = 4,
   parameter int CC_W         = 4,
   parameter int ALU_OP_W     = 2,
   parameter int AM_IMM       = 8,
   parameter int MEM_WAIT_MAX = 15
) (
   input  logic                clk,
   input  logic                rst_f,
   input  logic [OP_W-1:0]     opcode,
   input  logic [CC_W-1:0]     mm,
   input  logic [CC_W-1:0]     stat,
   input  logic                mem_ack,
   output logic                rf_we,
   output logic                wb_sel,
   output logic                rb_sel,
   output logic [ALU_OP_W-1:0] alu_op,
   output logic                pc_sel,
   output logic                pc_write,
   output logic                pc_rst,
   output logic                ir_load,
   output logic                br_sel,
   output logic                mem_req,
   output logic                mem_we,
   output logic                mem_err,
   output logic                halted,
   output logic [2:0]          state
);

   typedef enum logic [2:0] {
      S_START0    = 3'd0,
      S_START1    = 3'd1,
      S_FETCH     = 3'd2,
      S_DECODE    = 3'd3,
      S_EXECUTE   = 3'd4,
      S_MEM       = 3'd5,
      S_WRITEBACK = 3'd6,
      S_HALT      = 3'd7
   } state_t;

   localparam logic [OP_W-1:0] OP_NOOP = OP_W'(0);
   localparam logic [OP_W-1:0] OP_LOD  = OP_W'(1);
   localparam logic [OP_W-1:0] OP_STR  = OP_W'(2);
   localparam logic [OP_W-1:0] OP_SWP  = OP_W'(3);
   localparam logic [OP_W-1:0] OP_BRA  = OP_W'(4);
   localparam logic [OP_W-1:0] OP_BRR  = OP_W'(5);
   localparam logic [OP_W-1:0] OP_BNE  = OP_W'(6);
   localparam logic [OP_W-1:0] OP_BNR  = OP_W'(7);
   localparam logic [OP_W-1:0] OP_ALU  = OP_W'(8);
   localparam logic [OP_W-1:0] OP_HLT  = OP_W'(15);

   localparam logic [CC_W-1:0] MM_IMM   = CC_W'(AM_IMM);
   localparam logic [7:0]      WAIT_MAX = 8'(MEM_WAIT_MAX);

   state_t     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;

   logic       hit;
   logic       is_imm;
   logic       taken;
   logic       br_abs;
   logic       is_mem;
   logic       is_str;
   logic       is_lod;
   logic       rb_dst;
   logic       wb_en;
   logic [1:0] alu_sel;
   logic       in_wait;
   logic       timeout;

   assign hit    = (stat & mm) != '0;
   assign is_imm = (mm == MM_IMM);

   // Opcode classification shared by every state that uses it
   always_comb begin
      taken   = 1'b0;
      br_abs  = 1'b0;
      is_mem  = 1'b0;
      is_str  = 1'b0;
      is_lod  = 1'b0;
      rb_dst  = 1'b0;
      wb_en   = 1'b0;
      alu_sel = 2'b00;
      unique case (opcode)
         OP_LOD: begin
            is_mem  = 1'b1;
            is_lod  = 1'b1;
            wb_en   = 1'b1;
            alu_sel = {1'b1, is_imm};
         end
         OP_STR: begin
            is_mem  = 1'b1;
            is_str  = 1'b1;
            rb_dst  = 1'b1;
            alu_sel = {1'b1, is_imm};
         end
         OP_SWP: begin
            rb_dst  = 1'b1;
            wb_en   = 1'b1;
            alu_sel = {1'b1, is_imm};
         end
         OP_BRA: begin
            br_abs = 1'b1;
            taken  = hit;
         end
         OP_BRR: taken = hit;
         OP_BNE: begin
            br_abs = 1'b1;
            taken  = !hit;
         end
         OP_BNR: taken = !hit;
         OP_ALU: begin
            wb_en   = 1'b1;
            alu_sel = {1'b0, is_imm};
         end
         OP_NOOP, OP_HLT: ;
         default: ;
      endcase
   end

   // A memory op is still waiting when no ack has arrived yet
   assign in_wait = (state_q == S_MEM) && is_mem && !mem_ack;
   assign timeout = in_wait && (cnt_q == WAIT_MAX);

   // State register and handshake wait counter
   always_ff @(posedge clk or negedge rst_f) begin
      if (!rst_f) begin
         state_q <= S_START0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Counter only runs while waiting and clears on ack, timeout or exit
   always_comb begin
      cnt_d = '0;
      if (in_wait && !timeout) begin
         cnt_d = cnt_q + 8'd1;
      end
   end

   // Next-state sequencing
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_START0:    state_d = S_START1;
         S_START1:    state_d = S_FETCH;
         S_FETCH:     state_d = S_DECODE;
         S_DECODE: begin
            if (opcode == OP_HLT) state_d = S_HALT;
            else                  state_d = S_EXECUTE;
         end
         S_EXECUTE:   state_d = S_MEM;
         S_MEM: begin
            if (!is_mem || mem_ack) state_d = S_WRITEBACK;
            else if (timeout)       state_d = S_HALT;
            else                    state_d = S_MEM;
         end
         S_WRITEBACK: state_d = S_FETCH;
         S_HALT:      state_d = S_HALT;
         default:     state_d = S_START0;
      endcase
   end

   // Control strobes as a function of state and the current instruction
   always_comb begin
      rf_we    = 1'b0;
      wb_sel   = 1'b0;
      rb_sel   = 1'b0;
      alu_op   = '0;
      pc_sel   = 1'b0;
      pc_write = 1'b0;
      pc_rst   = 1'b0;
      ir_load  = 1'b0;
      br_sel   = 1'b0;
      mem_req  = 1'b0;
      mem_we   = 1'b0;
      mem_err  = 1'b0;
      halted   = 1'b0;
      unique case (state_q)
         S_START0, S_START1: pc_rst = 1'b1;
         S_FETCH: begin
            ir_load  = 1'b1;
            pc_write = 1'b1;
         end
         S_DECODE: begin
            br_sel = br_abs;
            if (taken) begin
               pc_sel   = 1'b1;
               pc_write = 1'b1;
            end
         end
         S_EXECUTE: begin
            alu_op = ALU_OP_W'(alu_sel);
            rb_sel = rb_dst;
         end
         S_MEM: begin
            alu_op = ALU_OP_W'(alu_sel);
            rb_sel = rb_dst;
            if (is_mem) begin
               mem_req = 1'b1;
               mem_we  = is_str;
               mem_err = timeout;
            end
         end
         S_WRITEBACK: begin
            alu_op = ALU_OP_W'(alu_sel);
            rb_sel = rb_dst;
            rf_we  = wb_en;
            wb_sel = is_lod;
         end
         S_HALT: halted = 1'b1;
         default: ;
      endcase
   end

   assign state = state_q;

endmodule

// File: doc/sisc_ctrl_mc.md
Name: sisc_ctrl_mc

Overview:
Multi-cycle control FSM for the SISC datapath. It supersedes the fixed-width controller. Generalisations:
- opcode, condition-code and ALU-op widths are parameters.
- LOD/STR use a request/acknowledge memory handshake with a bounded wait and a timeout.
- HLT enters a held HALT state instead of stopping simulation.

It sits between the IR/status register and the PC, register-file, ALU and memory-port control inputs.

Parameters:
OP_W, 4, opcode width
CC_W, 4, width of mm (condition mask / addressing mode) and stat
ALU_OP_W, 2, alu_op width (must be >= 2; upper bits driven 0)
AM_IMM, 8, mm value selecting immediate addressing
MEM_WAIT_MAX, 15, max cycles in MEM awaiting mem_ack before timeout (1..255)

Ports:
clk  in  1  system clock, rising edge
rst_f  in  1  reset, asynchronous, active-low
opcode  in  OP_W  current IR opcode (NOOP=0 LOD=1 STR=2 SWP=3 BRA=4 BRR=5 BNE=6 BNR=7 ALU_OP=8 HLT=15)
mm  in  CC_W  IR mm field
stat  in  CC_W  status flags
mem_ack  in  1  memory transfer complete
rf_we  out  1  register-file write enable
wb_sel  out  1  writeback source: 0 ALU, 1 memory
rb_sel  out  1  read-port B select: 1 selects destination register (SWP/STR)
alu_op  out  ALU_OP_W  ALU function
pc_sel  out  1  PC source: 0 increment, 1 branch target
pc_write  out  1  PC load enable
pc_rst  out  1  PC reset
ir_load  out  1  IR load enable
br_sel  out  1  branch target: 1 absolute, 0 relative
mem_req  out  1  memory request
mem_we  out  1  memory write (valid with mem_req)
mem_err  out  1  one-cycle pulse on handshake timeout
halted  out  1  FSM is in HALT
state  out  3  present state (debug)

Behaviour:
- State register and the wait counter are the only sequential elements. All other outputs are combinational functions of state, opcode, mm and stat. Outputs not listed for a state are 0.
- States: START0=0, START1=1, FETCH=2, DECODE=3, EXECUTE=4, MEM=5, WRITEBACK=6, HALT=7.
- rst_f low, asynchronously: state=START0 and counter=0.
- START0/START1 outputs: pc_rst=1; all enables 0; alu_op=0.
- Transitions: START0->START1->FETCH->DECODE.
  - DECODE->HALT if opcode==HLT, else DECODE->EXECUTE.
  - EXECUTE->MEM.
  - MEM->WRITEBACK per the handshake rules below.
  - WRITEBACK->FETCH.
  - HALT->HALT until reset.
- FETCH: ir_load=1, pc_write=1, pc_sel=0.
- DECODE branch evaluation, with hit = (stat & mm) != 0:
  - BRA: br_sel=1, taken if hit.
  - BRR: br_sel=0, taken if hit.
  - BNE: br_sel=1, taken if !hit.
  - BNR: br_sel=0, taken if !hit.
  - Taken: pc_sel=1, pc_write=1. Not taken, or any non-branch: pc_write=0.
- alu_op in EXECUTE, MEM and WRITEBACK:
  - ALU_OP: 01 if mm==AM_IMM, else 00.
  - LOD/STR/SWP: 11 if mm==AM_IMM, else 10.
  - Any other opcode: 00.
- rb_sel=1 in EXECUTE, MEM and WRITEBACK for STR and SWP.
- MEM, LOD or STR:
  - mem_req=1; mem_we=1 for STR.
  - Counter increments each cycle in MEM without mem_ack.
  - mem_ack=1 -> WRITEBACK next edge; counter cleared.
  - If the counter equals MEM_WAIT_MAX and mem_ack=0: mem_err=1 that cycle, next state HALT.
  - mem_ack on the timeout cycle wins: WRITEBACK, no mem_err.
- MEM, any other opcode: one cycle, mem_req=0, mem_ack ignored.
- WRITEBACK:
  - rf_we=1 for ALU_OP, LOD and SWP.
  - wb_sel=1 for LOD.
  - NOOP, STR and branches: no writes.
- HALT: halted=1, all enables 0, mem_req=0. Only rst_f exits.
- Reset mid-transaction (e.g. in MEM with mem_req=1): mem_req drops immediately (asynchronously). No mem_err. Counter cleared.
- mm/stat/opcode are sampled combinationally. The datapath holds them stable from DECODE to WRITEBACK.

Test Plan:
- Reset then ALU_OP, mm=0 -> state 0,1,2,3,4,5,6,2. FETCH: ir_load=1, pc_write=1. WRITEBACK: rf_we=1, wb_sel=0, alu_op=00. Immediate variant (mm=8): alu_op=01.
- Branches with stat=0010: BRA mm=0010 -> DECODE pc_sel=1, pc_write=1, br_sel=1. BNE mm=0010 -> pc_write=0, br_sel=1. BNR mm=0100 -> taken, br_sel=0. BRR mm=0100 -> not taken.
- LOD, mem_ack after 3 cycles -> mem_req=1 for 4 MEM cycles, mem_we=0. WRITEBACK: rf_we=1, wb_sel=1. STR, same timing -> mem_we=1, rb_sel=1, rf_we=0.
- STR, mem_ack never asserted, MEM_WAIT_MAX=15 -> 16 cycles in MEM. mem_err=1 on the last cycle. Then state=7, halted=1 held for 50 cycles. mem_ack asserted exactly on the timeout cycle -> WRITEBACK, mem_err stays 0.
- HLT -> DECODE->HALT, no pc_write. halted=1 until rst_f low. After release: START0 with pc_rst=1.
- rst_f pulsed low mid-clock during LOD in MEM -> state=0 and mem_req=0 before the next edge. Sequence restarts cleanly.
